reg_writeback_ctrl: RTL and testbench
=====================================

// Module: reg_writeback_ctrl
// PURPOSE
//  Write-side sequencer for the 32x32 register file: accepts retiring results
//  (ALU, PC+4, load), waits for data-memory returns, sign/zero-extends loads, and
//  drives the register-file write port (we/a3/wd3) one registered cycle later.
//  Tracks the single outstanding load destination and flags read-after-load
//  hazards for the decode stage's A1/A2 read addresses.
// PARAMETERS
//  TIMEOUT   16   max WAIT_MEM cycles before the load is abandoned (>=2)
//  CNT_W     5    width of the timeout counter (2**CNT_W > TIMEOUT)
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous reset, active low
//  req_valid    in   1   retire request valid
//  req_ready    out  1   request accepted when valid&ready
//  req_rd       in   5   destination register
//  req_src      in   2   00 ALU, 01 LOAD, 10 PC+4, 11 none (no write)
//  req_funct3   in   3   load type: 000 LB,001 LH,010 LW,100 LBU,101 LHU
//  req_alu      in   32  ALU result
//  req_pc4      in   32  PC+4 (JAL/JALR link)
//  req_addr_lo  in   2   load byte address [1:0]
//  mem_rvalid   in   1   load data valid
//  mem_rdata    in   32  load word (aligned)
//  rd_a1,rd_a2  in   5   decode read addresses (hazard check)
//  hazard       out  1   stall decode: read hits pending load rd
//  rf_we        out  1   register-file write enable (WE3)
//  rf_a3        out  5   write address (A3)
//  rf_wd3       out  32  write data (WD3)
//  load_err     out  1   one-cycle pulse: load timed out, no write
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state IDLE, rf_we=0, rf_a3=0, rf_wd3=0, load_err=0,
//    counter=0, pend_rd=0; req_ready and hazard forced 0 while rst=0.
//  - States: IDLE, WAIT_MEM. req_ready = (state==IDLE) & rst.
//  - IDLE, accept src ALU/PC4: next cycle rf_we=1, rf_a3=rd, rf_wd3=alu/pc4
//    (latency 1); back-to-back accepts give one write per cycle.
//  - IDLE, accept LOAD: latch rd/funct3/addr_lo -> WAIT_MEM, counter=0.
//  - WAIT_MEM & mem_rvalid: next cycle rf_we=1 with extended data; -> IDLE.
//    Extension: LB/LBU byte addr_lo, LH/LHU half addr_lo[1], LW/other = word.
//  - WAIT_MEM & !mem_rvalid: counter++; at counter==TIMEOUT-1 -> IDLE,
//    load_err=1 next cycle, no write. rvalid on that same cycle wins (write).
//  - rd==0 or src==11: request accepted, rf_we stays 0 (x0 never written).
//  - mem_rvalid in IDLE ignored. rf_we=0 in every cycle not listed above.
//  - hazard = (state==WAIT_MEM) & pend_rd!=0 & (rd_a1==pend_rd | rd_a2==pend_rd);
//    combinational.
//  - Reset during WAIT_MEM abandons load: no write, no load_err.
// CONFIGURATION
//  WB_BYPASS_EN defined: adds outputs byp1_hit, byp2_hit (1b) and byp_data (32b);
//   hit = rf_we & rf_a3!=0 & rf_a3==rd_a1/rd_a2, byp_data=rf_wd3, so decode uses
//   same-cycle write data. Undefined: ports absent; decode sees write next cycle.
// STRUCTURE
//  Shared package: state encoding (IDLE/WAIT_MEM), SRC_ALU/LOAD/PC4/NONE,
//  funct3 load codes (F3_LB..F3_LHU).
//  Sub-module load_extend (combinational: funct3, addr_lo, rdata -> 32b data).
// TESTING
//  ALU rd=5 alu=0x1234 -> next cycle rf_we=1 a3=5 wd3=0x00001234, ready stays 1.
//  LOAD LB rd=9 addr_lo=2, rvalid 3 cycles later rdata=0x11803344 ->
//   hazard=1 for rd_a1=9 while waiting; write a3=9 wd3=0xFFFFFF80.
//  LHU addr_lo=2 rdata=0x8001_0000 -> wd3=0x00008001; LW -> full word.
//  rd=0 ALU alu=0xDEAD -> rf_we stays 0; req_src=11 -> no write.
//  LOAD, no rvalid for TIMEOUT=16 cycles -> load_err pulse, no write,
//   ready=1 again.
//  rst=0 mid WAIT_MEM then rvalid -> no write; WB_BYPASS_EN: byp1_hit=1 when
//   rd_a1==rf_a3.

Source files
------------

// File: rtl/reg_writeback_ctrl_pkg.sv
// rtl/reg_writeback_ctrl_pkg.sv - shared types and codes for the register writeback controller
// Purpose: FSM state encoding, retire source codes and load funct3 codes.
// Ports: none (package).
package reg_writeback_ctrl_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;
  localparam logic [1:0] SRC_NONE = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// rtl/reg_writeback_ctrl_if.sv - retire request and data-memory return bundle
// Purpose: groups the retire handshake and the load-return signals.
// Ports (master drives / slave receives):
//   req_valid, req_rd, req_src, req_funct3, req_alu, req_pc4, req_addr_lo,
//   mem_rvalid, mem_rdata : master -> slave
//   req_ready             : slave -> master
interface reg_writeback_ctrl_if;
  import reg_writeback_ctrl_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rd;
  logic [1:0]  req_src;
  logic [2:0]  req_funct3;
  logic [31:0] req_alu;
  logic [31:0] req_pc4;
  logic [1:0]  req_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_rd, req_src, req_funct3, req_alu, req_pc4, req_addr_lo,
    output mem_rvalid, mem_rdata,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_rd, req_src, req_funct3, req_alu, req_pc4, req_addr_lo,
    input  mem_rvalid, mem_rdata,
    output req_ready
  );
endinterface

// File: rtl/reg_writeback_ctrl_load_extend.sv
// rtl/reg_writeback_ctrl_load_extend.sv - load byte/half selection and sign/zero extension
// Purpose: picks the addressed byte/halfword out of an aligned load word and extends it.
// Ports: funct3 (in 3), addr_lo (in 2), rdata (in 32), data (out 32).
module load_extend
  import reg_writeback_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // Halfword loads are assumed aligned, so only addr_lo[1] selects.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// rtl/reg_writeback_ctrl.sv - register-file write sequencer with load tracking and hazard flag
// Purpose: retires ALU/PC+4/load results onto the register-file write port one
//   registered cycle later, waits for one outstanding load with a timeout, and
//   flags read-after-load hazards for decode.
// Ports: clk, rst (sync active-low); bus (reg_writeback_ctrl_if.slave);
//   rd_a1, rd_a2 (in 5); hazard (out); rf_we, rf_a3, rf_wd3 (write port);
//   load_err (out, one-cycle pulse).
// Config: WB_BYPASS_EN adds byp1_hit, byp2_hit, byp_data.
module reg_writeback_ctrl
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_writeback_ctrl_if.slave  bus,
  input  logic [4:0]           rd_a1,
  input  logic [4:0]           rd_a2,
  output logic                 hazard,
  output logic                 rf_we,
  output logic [4:0]           rf_a3,
  output logic [31:0]          rf_wd3,
`ifdef WB_BYPASS_EN
  output logic                 byp1_hit,
  output logic                 byp2_hit,
  output logic [31:0]          byp_data,
`else
`endif
  output logic                 load_err
);

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [4:0]      pend_rd;
  logic [2:0]      pend_f3;
  logic [1:0]      pend_lo;
  logic [31:0]     ext_data;
  logic            accept;
  logic            timeout_hit;
  logic            we_nxt, err_nxt;
  logic [4:0]      a3_nxt;
  logic [31:0]     wd_nxt;

  load_extend u_load_extend (
    .funct3  (pend_f3),
    .addr_lo (pend_lo),
    .rdata   (bus.mem_rdata),
    .data    (ext_data)
  );

  assign bus.req_ready = (state == IDLE) & rst;
  assign accept        = bus.req_valid & bus.req_ready;
  assign timeout_hit   = (cnt == CNT_W'(TIMEOUT - 1));

  assign hazard = rst & (state == WAIT_MEM) & (pend_rd != 5'd0) &
                  ((rd_a1 == pend_rd) | (rd_a2 == pend_rd));

`ifdef WB_BYPASS_EN
  assign byp1_hit = rf_we & (rf_a3 != 5'd0) & (rf_a3 == rd_a1);
  assign byp2_hit = rf_we & (rf_a3 != 5'd0) & (rf_a3 == rd_a2);
  assign byp_data = rf_wd3;
`else
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    we_nxt    = 1'b0;
    err_nxt   = 1'b0;
    a3_nxt    = bus.req_rd;
    wd_nxt    = bus.req_alu;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.req_src)
            SRC_ALU:  we_nxt = (bus.req_rd != 5'd0);
            SRC_PC4: begin
              we_nxt = (bus.req_rd != 5'd0);
              wd_nxt = bus.req_pc4;
            end
            SRC_LOAD: state_nxt = WAIT_MEM;
            default:  ;
          endcase
        end
      end
      WAIT_MEM: begin
        // A return on the final timeout cycle still counts as a hit.
        if (bus.mem_rvalid) begin
          we_nxt    = (pend_rd != 5'd0);
          a3_nxt    = pend_rd;
          wd_nxt    = ext_data;
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_a3    <= 5'd0;
      rf_wd3   <= 32'd0;
      load_err <= 1'b0;
      cnt      <= '0;
      pend_rd  <= 5'd0;
      pend_f3  <= 3'd0;
      pend_lo  <= 2'd0;
    end else begin
      rf_we    <= we_nxt;
      load_err <= err_nxt;
      if (we_nxt) begin
        rf_a3  <= a3_nxt;
        rf_wd3 <= wd_nxt;
      end
      if (accept && bus.req_src == SRC_LOAD) begin
        pend_rd <= bus.req_rd;
        pend_f3 <= bus.req_funct3;
        pend_lo <= bus.req_addr_lo;
        cnt     <= '0;
      end else if (state == WAIT_MEM) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb/tb_reg_writeback_ctrl.sv - directed self-checking bench for reg_writeback_ctrl
module tb_reg_writeback_ctrl;
  import reg_writeback_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  rd_a1, rd_a2;
  logic        hazard;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic        load_err;
`ifdef WB_BYPASS_EN
  logic        byp1_hit, byp2_hit;
  logic [31:0] byp_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  reg_writeback_ctrl_if bus ();

  reg_writeback_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .rd_a1    (rd_a1),
    .rd_a2    (rd_a2),
    .hazard   (hazard),
    .rf_we    (rf_we),
    .rf_a3    (rf_a3),
    .rf_wd3   (rf_wd3),
`ifdef WB_BYPASS_EN
    .byp1_hit (byp1_hit),
    .byp2_hit (byp2_hit),
    .byp_data (byp_data),
`endif
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [4:0] rd, input logic [1:0] src, input logic [2:0] f3,
                     input logic [31:0] alu, input logic [31:0] pc4, input logic [1:0] lo);
    bus.req_valid   = 1'b1;
    bus.req_rd      = rd;
    bus.req_src     = src;
    bus.req_funct3  = f3;
    bus.req_alu     = alu;
    bus.req_pc4     = pc4;
    bus.req_addr_lo = lo;
  endtask

  task automatic load_and_return(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                                 input logic [1:0] lo, input logic [31:0] word,
                                 input logic [31:0] exp);
    req(rd, SRC_LOAD, f3, 32'd0, 32'd0, lo);
    step();
    bus.req_valid  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = word;
    step();
    bus.mem_rvalid = 1'b0;
    check({tag, "_we"}, {31'd0, rf_we}, 32'd1);
    check({tag, "_a3"}, {27'd0, rf_a3}, {27'd0, rd});
    check({tag, "_wd3"}, rf_wd3, exp);
  endtask

  initial begin
    rst = 1'b0;
    rd_a1 = 5'd0;
    rd_a2 = 5'd0;
    bus.req_valid = 1'b0;
    bus.req_rd = 5'd0;
    bus.req_src = SRC_NONE;
    bus.req_funct3 = 3'd0;
    bus.req_alu = 32'd0;
    bus.req_pc4 = 32'd0;
    bus.req_addr_lo = 2'd0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 32'd0;
    step();
    step();

    // Reset state
    check("rst_we", {31'd0, rf_we}, 32'd0);
    check("rst_a3", {27'd0, rf_a3}, 32'd0);
    check("rst_wd3", rf_wd3, 32'd0);
    check("rst_err", {31'd0, load_err}, 32'd0);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_hazard", {31'd0, hazard}, 32'd0);
    rst = 1'b1;
    #1;
    check("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

    // ALU then back-to-back PC+4
    req(5'd5, SRC_ALU, 3'd0, 32'h0000_1234, 32'd0, 2'd0);
    step();
    check("alu_we", {31'd0, rf_we}, 32'd1);
    check("alu_a3", {27'd0, rf_a3}, 32'd5);
    check("alu_wd3", rf_wd3, 32'h0000_1234);
    check("alu_ready", {31'd0, bus.req_ready}, 32'd1);
    req(5'd6, SRC_PC4, 3'd0, 32'hFFFF_FFFF, 32'h0000_0100, 2'd0);
    step();
    check("pc4_we", {31'd0, rf_we}, 32'd1);
    check("pc4_a3", {27'd0, rf_a3}, 32'd6);
    check("pc4_wd3", rf_wd3, 32'h0000_0100);
    bus.req_valid = 1'b0;
    step();
    check("idle_we", {31'd0, rf_we}, 32'd0);

    // LB rd=9 addr_lo=2, return three cycles after accept
    req(5'd9, SRC_LOAD, F3_LB, 32'd0, 32'd0, 2'd2);
    step();
    bus.req_valid = 1'b0;
    check("lb_wait_ready", {31'd0, bus.req_ready}, 32'd0);
    check("lb_wait_we", {31'd0, rf_we}, 32'd0);
    rd_a1 = 5'd9;
    #1;
    check("haz_a1", {31'd0, hazard}, 32'd1);
    rd_a1 = 5'd3;
    rd_a2 = 5'd9;
    #1;
    check("haz_a2", {31'd0, hazard}, 32'd1);
    rd_a2 = 5'd4;
    #1;
    check("haz_none", {31'd0, hazard}, 32'd0);
    rd_a1 = 5'd9;
    step();
    step();
    check("lb_still_wait", {31'd0, hazard}, 32'd1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h1180_3344;
    step();
    bus.mem_rvalid = 1'b0;
    check("lb_we", {31'd0, rf_we}, 32'd1);
    check("lb_a3", {27'd0, rf_a3}, 32'd9);
    check("lb_wd3", rf_wd3, 32'hFFFF_FF80);
    check("lb_ready", {31'd0, bus.req_ready}, 32'd1);
    check("lb_haz_clear", {31'd0, hazard}, 32'd0);

    // Stray rvalid in IDLE is ignored
    bus.mem_rvalid = 1'b1;
    step();
    bus.mem_rvalid = 1'b0;
    check("idle_rvalid_we", {31'd0, rf_we}, 32'd0);

    // Other load types
    load_and_return("lhu", 5'd10, F3_LHU, 2'd2, 32'h8001_0000, 32'h0000_8001);
    load_and_return("lw", 5'd11, F3_LW, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D);
    load_and_return("lh", 5'd12, F3_LH, 2'd0, 32'h1234_8765, 32'hFFFF_8765);
    load_and_return("lbu", 5'd16, F3_LBU, 2'd3, 32'h9A00_0000, 32'h0000_009A);

    // x0 and SRC_NONE never write
    req(5'd0, SRC_ALU, 3'd0, 32'h0000_DEAD, 32'd0, 2'd0);
    step();
    check("x0_we", {31'd0, rf_we}, 32'd0);
    req(5'd7, SRC_NONE, 3'd0, 32'h0000_BEEF, 32'd0, 2'd0);
    step();
    bus.req_valid = 1'b0;
    check("none_we", {31'd0, rf_we}, 32'd0);
    check("none_ready", {31'd0, bus.req_ready}, 32'd1);

    // Timeout: 16 cycles in WAIT_MEM with no return
    req(5'd13, SRC_LOAD, F3_LW, 32'd0, 32'd0, 2'd0);
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("to_pre_ready", {31'd0, bus.req_ready}, 32'd0);
    check("to_pre_err", {31'd0, load_err}, 32'd0);
    step();
    check("to_err", {31'd0, load_err}, 32'd1);
    check("to_we", {31'd0, rf_we}, 32'd0);
    check("to_ready", {31'd0, bus.req_ready}, 32'd1);
    step();
    check("to_err_pulse", {31'd0, load_err}, 32'd0);

    // Return on the final timeout cycle wins
    req(5'd14, SRC_LOAD, F3_LW, 32'd0, 32'd0, 2'd0);
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h0000_0055;
    step();
    bus.mem_rvalid = 1'b0;
    check("late_we", {31'd0, rf_we}, 32'd1);
    check("late_a3", {27'd0, rf_a3}, 32'd14);
    check("late_wd3", rf_wd3, 32'h0000_0055);
    check("late_err", {31'd0, load_err}, 32'd0);

    // Reset while waiting abandons the load
    req(5'd15, SRC_LOAD, F3_LW, 32'd0, 32'd0, 2'd0);
    step();
    bus.req_valid = 1'b0;
    rd_a1 = 5'd15;
    step();
    rst = 1'b0;
    #1;
    check("rstw_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rstw_hazard", {31'd0, hazard}, 32'd0);
    step();
    rst = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    step();
    bus.mem_rvalid = 1'b0;
    check("rstw_we", {31'd0, rf_we}, 32'd0);
    check("rstw_err", {31'd0, load_err}, 32'd0);
    check("rstw_ready2", {31'd0, bus.req_ready}, 32'd1);

`ifdef WB_BYPASS_EN
    req(5'd20, SRC_ALU, 3'd0, 32'h0BAD_F00D, 32'd0, 2'd0);
    rd_a1 = 5'd20;
    rd_a2 = 5'd21;
    step();
    bus.req_valid = 1'b0;
    check("byp1_hit", {31'd0, byp1_hit}, 32'd1);
    check("byp2_hit", {31'd0, byp2_hit}, 32'd0);
    check("byp_data", byp_data, 32'h0BAD_F00D);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
